// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals of mem_port_arbiter.
// The arbiter uses the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);
  // Handshake: *_req_i is valid and *_gnt_o is ready, so a command transfers in
  // any cycle where both are high. An ungranted requester holds req and payload
  // stable or drops req. Read responses (*_rvalid_o) cannot be back-pressured.
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_gnt_o;
  logic              i_rvalid_o;
  logic [31:0]       i_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [7:0]        d_be_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [63:0]       d_wdata_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [63:0]       d_rdata_o;

  logic              m_req_o;
  logic              m_we_o;
  logic [7:0]        m_be_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [63:0]       m_wdata_o;
  logic [63:0]       m_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    input  m_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
    output m_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter for a single-ported memory with a latency-matched read tag pipe.
// Define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation guard.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef struct packed {
    logic valid;
    logic own_i;
    logic hi;
  } tag_t;

  logic              i_gnt;
  logic              d_gnt;
  logic              force_i;
  logic              m_req;
  logic              m_we;
  logic [7:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_wdata;
  tag_t              tags [MEM_LAT];
  tag_t              tail;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  // Counts D grants taken while fetch is waiting; at the limit fetch wins once.
  assign force_i = bus.i_req_i && (starve_cnt == 4'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!bus.i_req_i || i_gnt) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  logic unused_starve_max;

  assign force_i           = 1'b0;
  assign unused_starve_max = ^4'(STARVE_MAX);
`endif

  // Grants are held low during reset so stall sources stay quiet.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (bus.d_req_i && !force_i) begin
        d_gnt = 1'b1;
      end else if (bus.i_req_i) begin
        i_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_we    = 1'b0;
    m_be    = 8'h00;
    m_addr  = '0;
    m_wdata = 64'h0;
    if (d_gnt) begin
      m_we    = bus.d_we_i;
      m_be    = bus.d_be_i;
      m_addr  = bus.d_addr_i;
      m_wdata = bus.d_wdata_i;
    end else if (i_gnt) begin
      m_be   = 8'hFF;
      m_addr = bus.i_addr_i;
    end
  end

  assign m_req = i_gnt | d_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MEM_LAT; s++) begin
        tags[s] <= '0;
      end
    end else begin
      tags[0] <= '{valid: m_req & ~m_we, own_i: i_gnt, hi: m_addr[2]};
      for (int s = 1; s < MEM_LAT; s++) begin
        tags[s] <= tags[s-1];
      end
    end
  end

  // Read data is forced to zero whenever no response is being delivered.
  assign tail           = tags[MEM_LAT-1];
  assign bus.i_rvalid_o = tail.valid & tail.own_i;
  assign bus.d_rvalid_o = tail.valid & ~tail.own_i;
  assign bus.i_rdata_o  = !bus.i_rvalid_o ? 32'h0 :
                          (tail.hi ? bus.m_rdata_i[63:32] : bus.m_rdata_i[31:0]);
  assign bus.d_rdata_o  = bus.d_rvalid_o ? bus.m_rdata_i : 64'h0;

  assign bus.i_gnt_o   = i_gnt;
  assign bus.d_gnt_o   = d_gnt;
  assign bus.m_req_o   = m_req;
  assign bus.m_we_o    = m_we;
  assign bus.m_be_o    = m_be;
  assign bus.m_addr_o  = m_addr;
  assign bus.m_wdata_o = m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grants, memory commands and ordered read returns.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic              i_gnt;
    logic              d_gnt;
    logic              m_req;
    logic              m_we;
    logic [7:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_wdata;
    logic              i_rv;
    logic [31:0]       i_rd;
    logic              d_rv;
    logic [63:0]       d_rd;
  } out_t;

  typedef struct packed {
    int          due;
    logic        own_i;
    logic [63:0] data;
  } resp_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- memory model (read-only pattern) ----------------
  function automatic logic [63:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = a[34:3];
    return {w ^ 32'hAAAA_BBBB, w ^ 32'hCCCC_DDDD};
  endfunction

  logic [63:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    for (int s = MEM_LAT - 1; s > 0; s--) rd_pipe[s] <= rd_pipe[s-1];
    rd_pipe[0] <= (bus.m_req_o && !bus.m_we_o) ? mem_word(bus.m_addr_o)
                                                : 64'h0BAD_0BAD_0BAD_0BAD;
  end
  assign bus.m_rdata_i = rd_pipe[MEM_LAT-1];

  // ---------------- stimulus state and reference model ----------------
  logic              ir, dr, dwe;
  logic [ADDR_W-1:0] ia, da;
  logic [63:0]       dwd;
  logic [7:0]        dbe;

  resp_t exp_q[$];
  int    wait_cnt = 0;   // consecutive D grants taken while I was requesting
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  task automatic apply();
    bus.i_req_i   = ir;
    bus.i_addr_i  = ia;
    bus.d_req_i   = dr;
    bus.d_we_i    = dwe;
    bus.d_be_i    = dbe;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dwd;
  endtask

  function automatic out_t model_out();
    out_t e;
    bit   starved;
    e = '0;
    starved = GUARD && ir && (wait_cnt == STARVE_MAX);
    if (dr && !starved) e.d_gnt = 1'b1;
    else if (ir)        e.i_gnt = 1'b1;
    e.m_req = e.i_gnt | e.d_gnt;
    if (e.d_gnt) begin
      e.m_we = dwe; e.m_be = dbe; e.m_addr = da; e.m_wdata = dwd;
    end else if (e.i_gnt) begin
      e.m_be = 8'hFF; e.m_addr = ia;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].own_i) begin e.i_rv = 1'b1; e.i_rd = exp_q[0].data[31:0]; end
      else                begin e.d_rv = 1'b1; e.d_rd = exp_q[0].data;       end
    end
    return e;
  endfunction

  task automatic commit(input out_t e);
    logic [63:0] w;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
    if (e.m_req && !e.m_we) begin
      if (e.i_gnt) begin
        w = mem_word(ia);
        exp_q.push_back('{due: cyc + MEM_LAT, own_i: 1'b1,
                          data: {32'h0, (ia[2] ? w[63:32] : w[31:0])}});
      end else begin
        exp_q.push_back('{due: cyc + MEM_LAT, own_i: 1'b0, data: mem_word(da)});
      end
    end
    wait_cnt = (e.d_gnt && ir) ? wait_cnt + 1 : 0;
    cyc++;
  endtask

  task automatic sample(input bit raw, output out_t o);
    o.i_gnt   = bus.i_gnt_o;
    o.d_gnt   = bus.d_gnt_o;
    o.m_req   = bus.m_req_o;
    o.m_we    = bus.m_we_o;
    o.m_be    = bus.m_be_o;
    o.m_addr  = bus.m_addr_o;
    o.m_wdata = bus.m_wdata_o;
    o.i_rv    = bus.i_rvalid_o;
    o.i_rd    = (raw || bus.i_rvalid_o) ? bus.i_rdata_o : 32'h0;
    o.d_rv    = bus.d_rvalid_o;
    o.d_rd    = (raw || bus.d_rvalid_o) ? bus.d_rdata_o : 64'h0;
  endtask

  task automatic idle_inputs();
    ir = 0; dr = 0; dwe = 0; ia = '0; da = '0; dbe = '0; dwd = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_t o;
    rst_n = 1'b0;
    ir = 1; ia = 64'h1004; dr = 1; dwe = 0; da = 64'h100; dbe = 8'hFF; dwd = '0;
    apply();
    #1;
    sample(1'b1, o);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_async got=%h exp=0", o); end
    repeat (2) @(posedge clk);
    #1;
    sample(1'b1, o);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL reset_held got=%h exp=0", o); end
    idle_inputs(); apply();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); wait_cnt = 0; cyc = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_i_read();
    out_t e, o;
    for (int k = 0; k <= MEM_LAT + 1; k++) begin
      idle_inputs();
      if (k == 0) begin ir = 1; ia = 64'h1004; end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL i_read k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    out_t e, o;
    for (int k = 0; k <= MEM_LAT + 2; k++) begin
      idle_inputs();
      if (k <= 1) begin ir = 1; ia = 64'h0; end
      if (k == 0) begin dr = 1; da = 64'h100; dbe = 8'hFF; end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL collision k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_d_write();
    out_t e, o;
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k == 0) begin
        dr = 1; dwe = 1; da = 64'h200; dbe = 8'h0F; dwd = 64'h1122_3344;
      end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL d_write k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_starvation();
    out_t e, o;
    int   i_grants = 0;
    for (int k = 0; k < 10 + MEM_LAT + 1; k++) begin
      idle_inputs();
      if (k < 10) begin
        ir = 1; ia = 64'h40;
        dr = 1; da = 64'h800 + 64'(8 * k); dbe = 8'hFF;
      end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      if (k < 10 && o.i_gnt === 1'b1) i_grants++;
      checks++;
      if (o !== e) begin failures++; $display("FAIL starvation k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
    checks++;
    if (i_grants != (GUARD ? 10 / (STARVE_MAX + 1) : 0)) begin
      failures++;
      $display("FAIL starvation_i_grants got=%0d exp=%0d", i_grants,
               (GUARD ? 10 / (STARVE_MAX + 1) : 0));
    end
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    for (int k = 0; k < 6 + MEM_LAT + 1; k++) begin
      idle_inputs();
      if (k < 6 && k % 2 == 0) begin ir = 1; ia = 64'h8; end
      if (k < 6 && k % 2 == 1) begin dr = 1; da = 64'h10; dbe = 8'hFF; end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL back_to_back k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    out_t e, o;
    idle_inputs();
    for (int k = 0; k < 300 + MEM_LAT + 1; k++) begin
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL random k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
      if (k >= 299) begin
        idle_inputs();
      end else begin
        if (e.i_gnt || !ir || $urandom_range(9) == 0) begin
          ir = 1'($urandom_range(1));
          ia = {$urandom, $urandom} & ~64'h3;
        end
        if (e.d_gnt || !dr || $urandom_range(9) == 0) begin
          dr  = 1'($urandom_range(1));
          dwe = 1'($urandom_range(1));
          dbe = 8'($urandom);
          da  = {$urandom, $urandom};
          dwd = {$urandom, $urandom};
        end
      end
    end
  endtask

  task automatic test_reset_flight();
    out_t e, o;
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      ir = 1; ia = 64'h8;
      if (k == 0) begin dr = 1; da = 64'h10; dbe = 8'hFF; end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL flight_issue k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
    idle_inputs(); ir = 1; dr = 1; dbe = 8'hFF; apply();
    #2 rst_n = 1'b0;
    #1;
    sample(1'b1, o);
    checks++;
    if (o !== '0) begin failures++; $display("FAIL flight_reset got=%h exp=0", o); end
    @(posedge clk);
    idle_inputs(); apply();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); wait_cnt = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 5 + 6 + MEM_LAT + 1; k++) begin
      idle_inputs();
      if (k >= 5 && k < 11) begin
        ir = 1; ia = 64'h20; dr = 1; da = 64'h30 + 64'(8 * k); dbe = 8'hFF;
      end
      apply();
      @(negedge clk);
      e = model_out(); sample(1'b0, o);
      checks++;
      if (o !== e) begin failures++; $display("FAIL flight_after k=%0d got=%h exp=%h", k, o, e); end
      commit(e);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    apply();
    test_reset();
    test_i_read();
    test_collision();
    test_d_write();
    test_starvation();
    test_back_to_back();
    test_random();
    test_reset_flight();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
